mem_arbiter: RTL

//  Shares the single 32-bit memory port between the core's instruction-fetch

---
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 32-bit memory port between instruction
// fetch (IF) and load/store (DATA), one transaction outstanding, with a
// watchdog that converts hung accesses into error responses.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_valid,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_rsp_valid,
  output logic        if_rsp_err,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic        d_we,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ready,
  output logic        d_rsp_valid,
  output logic        d_rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t              state, state_n;
  logic                last_d;      // 1 when DATA held the most recent grant
  logic                owner_d;     // owner of the transaction in flight
  logic [CNT_W-1:0]    wd, wd_n;
  logic                grant_if, grant_d;
  logic                mem_valid_n;
  logic                rsp_fire, rsp_err_n;
  logic [DATA_W-1:0]   rsp_data_n;

  // Grants are visible to the requesters in the same IDLE cycle.
  assign if_ready = grant_if;
  assign d_ready  = grant_d;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Next-state, arbitration, watchdog and response decode.
  always_comb begin
    state_n     = state;
    grant_if    = 1'b0;
    grant_d     = 1'b0;
    wd_n        = wd;
    mem_valid_n = 1'b0;
    rsp_fire    = 1'b0;
    rsp_err_n   = 1'b0;
    rsp_data_n  = '0;
    case (state)
      IDLE: begin
        // On a tie, the requester that did not win last time goes first.
        if (if_valid && (!d_valid || last_d)) grant_if = 1'b1;
        else if (d_valid)                     grant_d  = 1'b1;
        if (grant_if || grant_d) begin
          state_n     = ISSUE;
          mem_valid_n = 1'b1;
        end
      end
      ISSUE: begin
        mem_valid_n = 1'b1;
        if (mem_ready) begin
          state_n     = WAIT;
          mem_valid_n = 1'b0;
          wd_n        = '0;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          rsp_fire   = 1'b1;
          rsp_data_n = mem_we ? '0 : mem_rdata;
          state_n    = IDLE;
        end else if ((TIMEOUT != 0) && (wd == CNT_W'(TIMEOUT - 1))) begin
          rsp_fire  = 1'b1;
          rsp_err_n = 1'b1;
          state_n   = IDLE;
        end else begin
          wd_n = wd + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Request latch, round-robin history and memory-side request valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_d    <= 1'b1;
      owner_d   <= 1'b0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      wd        <= '0;
    end else begin
      mem_valid <= mem_valid_n;
      wd        <= wd_n;
      if (grant_if || grant_d) begin
        last_d    <= grant_d;
        owner_d   <= grant_d;
        mem_addr  <= grant_d ? d_addr : if_addr;
        mem_we    <= grant_d & d_we;
        mem_wdata <= grant_d ? d_wdata : DATA_W'(0);
        mem_wstrb <= (grant_d && d_we) ? d_wstrb : STRB_W'(0);
      end
    end
  end

  // Registered one-cycle response pulse routed to the transaction owner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_rsp_valid <= 1'b0;
      if_rsp_err   <= 1'b0;
      d_rsp_valid  <= 1'b0;
      d_rsp_err    <= 1'b0;
      rsp_rdata    <= '0;
    end else begin
      if_rsp_valid <= rsp_fire & ~owner_d;
      if_rsp_err   <= rsp_fire & rsp_err_n & ~owner_d;
      d_rsp_valid  <= rsp_fire & owner_d;
      d_rsp_err    <= rsp_fire & rsp_err_n & owner_d;
      rsp_rdata    <= rsp_data_n;
    end
  end

endmodule
